// File: rtl/shift_right_seq_if.sv
// rtl/shift_right_seq_if.sv - request/response handshake bundle for the multi-cycle right shifter
interface shift_right_seq_if #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  din;
  logic [SHAMT_W-1:0] shamt;
  logic               arith;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  dout;

  modport master (
    output in_valid, din, shamt, arith, out_ready,
    input  in_ready, out_valid, dout
  );

  modport slave (
    input  in_valid, din, shamt, arith, out_ready,
    output in_ready, out_valid, dout
  );
endinterface

// File: rtl/shift_right_seq.sv
// rtl/shift_right_seq.sv - iterative SRL/SRA shifter with valid/ready on both sides
// Optional SHR_FAST_EN: take 4-bit steps while at least 4 shifts remain.
module shift_right_seq #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  shift_right_seq_if.slave   bus,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   work_q,  work_d;
  logic [SHAMT_W-1:0]  count_q, count_d;
  logic                fill_q,  fill_d;

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    count_d = count_q;
    fill_d  = fill_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d  = bus.din;
          fill_d  = bus.arith & bus.din[DATA_W-1];
          count_d = bus.shamt;
          state_d = (bus.shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
`ifdef SHR_FAST_EN
        if (count_q >= SHAMT_W'(4)) begin
          work_d  = {{4{fill_q}}, work_q[DATA_W-1:4]};
          count_d = count_q - SHAMT_W'(4);
        end else begin
          work_d  = {fill_q, work_q[DATA_W-1:1]};
          count_d = count_q - SHAMT_W'(1);
        end
`else
        work_d  = {fill_q, work_q[DATA_W-1:1]};
        count_d = count_q - SHAMT_W'(1);
`endif
        // The step that exhausts the count is the last one; the result is complete on entry to DONE.
        if (count_d == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      count_q <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      count_q <= count_d;
      fill_q  <= fill_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.dout      = work_q;
  assign busy          = (state_q == SHIFT) || (state_q == DONE);

endmodule
